fir_prog: RTL



---
 rtl/fir_prog_pkg.sv | 43 ++++
 rtl/fir_prog_regs.sv | 54 +++++
 rtl/fir_prog.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fir_prog_pkg.sv
// fir_prog_pkg: shared FSM state type, index-width helper and output narrowing.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a. FIR_PROG_SAT_EN selects saturating narrowing; otherwise two's-complement wrap.
package fir_prog_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default tap count and the matching idx width; the modules derive their
    // own width from N_TAPS through idx_width().
    localparam int N_TAPS_DEF = 4;
    localparam int IDX_W_DEF  = $clog2(N_TAPS_DEF);

    function automatic int idx_width(input int n_taps);
        return (n_taps > 1) ? $clog2(n_taps) : 1;
    endfunction

    // Narrow a sign-extended value to bw_out signed bits. The result is
    // returned sign-extended to 64 bits; the caller keeps the low bw_out bits.
    function automatic logic signed [63:0] narrow(input logic signed [63:0] v,
                                                  input int bw_out);
`ifdef FIR_PROG_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bw_out - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bw_out - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
`else
        // Drop the upper bits and re-sign-extend from bit bw_out-1.
        return (v <<< (64 - bw_out)) >>> (64 - bw_out);
`endif
    endfunction

endpackage

// File: rtl/fir_prog_regs.sv
// fir_prog_regs: sample delay line and coefficient shift chain with an indexed read port.
// Latency: shifts take effect at the clock edge; the read port is combinational on idx.
// Backpressure: none; the shift strobes are qualified by the owning FSM.
//
// Ports: clk, rst (sync, active-low); x_shift/x_in push a sample into d[0];
// coef_shift/coef_in push a coefficient into coef[0]; idx selects d_rd/coef_rd.
module fir_prog_regs
    import fir_prog_pkg::*;
#(
    parameter int N_TAPS  = 4,
    parameter int BW_IN   = 4,
    parameter int BW_COEF = 4,
    parameter int IDX_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      x_shift,
    input  logic signed [BW_IN-1:0]   x_in,
    input  logic                      coef_shift,
    input  logic signed [BW_COEF-1:0] coef_in,
    input  logic        [IDX_W-1:0]   idx,
    output logic signed [BW_IN-1:0]   d_rd,
    output logic signed [BW_COEF-1:0] coef_rd
);

    logic signed [BW_IN-1:0]   d_line [N_TAPS];
    logic signed [BW_COEF-1:0] coef   [N_TAPS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < N_TAPS; k++) begin
                d_line[k] <= '0;
                coef[k]   <= '0;
            end
        end else begin
            if (x_shift) begin
                d_line[0] <= x_in;
                for (int k = 1; k < N_TAPS; k++) begin
                    d_line[k] <= d_line[k-1];
                end
            end
            if (coef_shift) begin
                coef[0] <= coef_in;
                for (int k = 1; k < N_TAPS; k++) begin
                    coef[k] <= coef[k-1];
                end
            end
        end
    end

    assign d_rd    = d_line[idx];
    assign coef_rd = coef[idx];

endmodule

// File: rtl/fir_prog.sv
// fir_prog: programmable-coefficient FIR, one shared MAC stepping one tap per cycle.
// Latency: sample accepted at E0, y_out/y_valid registered at E(N_TAPS+1).
// Backpressure: none; samples arriving while busy (or alongside coef_load) are dropped and set sticky overrun.
//
// Ports: clk; rst (sync, active-low); x_in/x_valid sample strobe; coef_in/coef_load
// coefficient shift strobe (IDLE only); y_out held result with one-cycle y_valid;
// busy = FSM not IDLE; overrun sticky dropped-sample flag.
// Build option: define FIR_PROG_SAT_EN for saturating output narrowing (default wraps).
module fir_prog
    import fir_prog_pkg::*;
#(
    parameter int N_TAPS    = 4,
    parameter int BW_IN     = 4,
    parameter int BW_COEF   = 4,
    parameter int BW_SUM    = 12,
    parameter int BW_OUT    = 8,
    parameter int OUT_SHIFT = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [BW_IN-1:0]   x_in,
    input  logic                      x_valid,
    input  logic signed [BW_COEF-1:0] coef_in,
    input  logic                      coef_load,
    output logic signed [BW_OUT-1:0]  y_out,
    output logic                      y_valid,
    output logic                      busy,
    output logic                      overrun
);

    localparam int IDX_W = idx_width(N_TAPS);
    localparam int PW    = BW_IN + BW_COEF;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TAPS - 1);

    state_t                    state;
    logic        [IDX_W-1:0]   idx;
    logic signed [BW_SUM-1:0]  acc;
    logic signed [BW_IN-1:0]   d_rd;
    logic signed [BW_COEF-1:0] coef_rd;
    logic signed [PW-1:0]      prod;
    logic                      x_shift;
    logic                      coef_shift;

    // Strobes only act in IDLE; coef_load wins over x_valid.
    assign coef_shift = (state == IDLE) && coef_load;
    assign x_shift    = (state == IDLE) && x_valid && !coef_load;

    fir_prog_regs #(
        .N_TAPS (N_TAPS),
        .BW_IN  (BW_IN),
        .BW_COEF(BW_COEF),
        .IDX_W  (IDX_W)
    ) u_regs (
        .clk       (clk),
        .rst       (rst),
        .x_shift   (x_shift),
        .x_in      (x_in),
        .coef_shift(coef_shift),
        .coef_in   (coef_in),
        .idx       (idx),
        .d_rd      (d_rd),
        .coef_rd   (coef_rd)
    );

    // Full-precision signed product; operands are sign-extended first.
    assign prod = PW'(d_rd) * PW'(coef_rd);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            idx     <= '0;
            acc     <= '0;
            y_out   <= '0;
            y_valid <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (x_valid) begin
                        if (coef_load) begin
                            overrun <= 1'b1;
                        end else begin
                            acc   <= '0;
                            idx   <= '0;
                            state <= MAC;
                            busy  <= 1'b1;
                        end
                    end
                end
                MAC: begin
                    if (x_valid) begin
                        overrun <= 1'b1;
                    end
                    // Accumulator wraps modulo 2^BW_SUM.
                    acc <= acc + BW_SUM'(prod);
                    idx <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (x_valid) begin
                        overrun <= 1'b1;
                    end
                    y_out   <= BW_OUT'(narrow(64'(acc >>> OUT_SHIFT), BW_OUT));
                    y_valid <= 1'b1;
                    state   <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
